fpu_add_sub_aligner: RTL and testbench

FPU_ADD_SUB_ALIGNER -- requirements
Module: fpu_add_sub_aligner

---
 rtl/fpu_add_sub_aligner_pkg.sv | 14 +
 rtl/fpu_add_sub_aligner_if.sv | 22 ++
 rtl/fpu_add_sub_aligner_shifter.sv | 20 ++
 rtl/fpu_add_sub_aligner.sv | 47 ++++
 tb/tb_fpu_add_sub_aligner.sv | 116 +++++++++++
 5 files changed

// File: rtl/fpu_add_sub_aligner_pkg.sv
// Shared half-precision types and field widths for the FPU add/sub datapath.
package fpu_lib;

    localparam int EXP_WIDTH  = 5;
    localparam int MANT_WIDTH = 10;
    localparam int SIG_WIDTH  = 11;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] mant;
    } fp16_t;

endpackage

// File: rtl/fpu_add_sub_aligner_if.sv
// Operand/result bundle between the add/sub front end and the aligner.
interface fpu_add_sub_aligner_if;
    import fpu_lib::*;

    logic  inValid;
    fp16_t largeNum;
    fp16_t smallNum;
    logic  outValid;
    fp16_t alignedSmallNum;
    logic  sticky;

    modport master (
        output inValid, largeNum, smallNum,
        input  outValid, alignedSmallNum, sticky
    );

    modport slave (
        input  inValid, largeNum, smallNum,
        output outValid, alignedSmallNum, sticky
    );

endinterface

// File: rtl/fpu_add_sub_aligner_shifter.sv
// Logical right shift of a significand that also reports whether any set bit fell off.
module fpuStickyRightShifter
    import fpu_lib::*;
(
    input  logic [SIG_WIDTH-1:0] data,
    input  logic [EXP_WIDTH-1:0] shamt,
    output logic [SIG_WIDTH-1:0] shifted,
    output logic                 sticky
);

    logic [SIG_WIDTH-1:0] lost_mask;

    // Shifts of SIG_WIDTH or more clear the result and make the mask all ones.
    always_comb begin
        shifted   = data >> shamt;
        lost_mask = ~({SIG_WIDTH{1'b1}} << shamt);
        sticky    = |(data & lost_mask);
    end

endmodule

// File: rtl/fpu_add_sub_aligner.sv
// Aligns the smaller-exponent operand to the larger one's exponent, one-cycle registered.
module fpu_add_sub_aligner
    import fpu_lib::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    fpu_add_sub_aligner_if.slave bus
);

    logic [EXP_WIDTH-1:0] shift;
    logic [SIG_WIDTH-1:0] small_sig;
    logic [SIG_WIDTH-1:0] shifted_sig;
    logic                 shift_sticky;

    // Denormals keep the raw exponent 0; a small exponent above the large one passes through.
    always_comb begin
        small_sig = {(bus.smallNum.exp != '0), bus.smallNum.mant};
        if (bus.smallNum.exp > bus.largeNum.exp)
            shift = '0;
        else
            shift = bus.largeNum.exp - bus.smallNum.exp;
    end

    fpuStickyRightShifter u_shifter (
        .data    (small_sig),
        .shamt   (shift),
        .shifted (shifted_sig),
        .sticky  (shift_sticky)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.outValid        <= 1'b0;
            bus.alignedSmallNum <= '0;
            bus.sticky          <= 1'b0;
        end else begin
            bus.outValid <= bus.inValid;
            if (bus.inValid) begin
                bus.alignedSmallNum.sign <= bus.smallNum.sign;
                bus.alignedSmallNum.exp  <= bus.largeNum.exp;
                bus.alignedSmallNum.mant <= shifted_sig[MANT_WIDTH-1:0];
                bus.sticky               <= shift_sticky;
            end
        end
    end

endmodule

// File: tb/tb_fpu_add_sub_aligner.sv
// Directed and random checks of fpu_add_sub_aligner against an arithmetic reference model.
module tb_fpu_add_sub_aligner;
    import fpu_lib::*;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    fpu_add_sub_aligner_if bus ();

    fpu_add_sub_aligner dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] ref_align(input logic [15:0] l, input logic [15:0] s);
        int     le, se, sig, sh, q, r;
        longint div;
        logic [15:0] res;
        le  = int'(l[14:10]);
        se  = int'(s[14:10]);
        sig = (se != 0 ? 1024 : 0) + int'(s[9:0]);
        sh  = (se > le) ? 0 : le - se;
        div = longint'(1) << sh;
        q   = int'(longint'(sig) / div);
        r   = int'(longint'(sig) % div);
        res = {s[15], l[14:10], 10'(q % 1024)};
        return {(r != 0), res};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] s);
        bus.inValid  = v;
        bus.largeNum = l;
        bus.smallNum = s;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] a, input logic st);
        chk({tag, "_valid"}, 16'(bus.outValid), 16'(v));
        chk({tag, "_aligned"}, 16'(bus.alignedSmallNum), a);
        chk({tag, "_sticky"}, 16'(bus.sticky), 16'(st));
    endtask

    initial begin
        logic [15:0] l, s, hold_a;
        logic [16:0] m;
        logic        v, hold_st;

        reset_n      = 1'b0;
        bus.inValid  = 1'b0;
        bus.largeNum = '0;
        bus.smallNum = '0;
        @(posedge clock);
        drive(1'b0, 16'h0000, 16'h0000);
        expect_out("reset", 1'b0, 16'h0000, 1'b0);
        reset_n = 1'b1;

        drive(1'b1, 16'h0000, 16'h0000);
        expect_out("zeros", 1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h89FF, 16'h01FF);
        expect_out("denormal", 1'b1, 16'h087F, 1'b1);
        drive(1'b1, 16'hDC00, 16'hC200);
        expect_out("normal", 1'b1, 16'hDC0C, 1'b0);
        drive(1'b1, 16'h7800, 16'h0400);
        expect_out("oversize", 1'b1, 16'h7800, 1'b1);
        drive(1'b1, 16'h3EAA, 16'h3EAA);
        expect_out("equal_exp", 1'b1, 16'h3EAA, 1'b0);
        drive(1'b1, 16'h0800, 16'h3C01);
        expect_out("small_exp_larger", 1'b1, 16'h0801, 1'b0);
        drive(1'b1, 16'h4000, 16'h3C01);
        expect_out("shift1_sticky", 1'b1, 16'h4200, 1'b1);
        drive(1'b0, 16'h1234, 16'h5678);
        expect_out("idle_hold", 1'b0, 16'h4200, 1'b1);

        reset_n = 1'b0;
        drive(1'b1, 16'h89FF, 16'h01FF);
        expect_out("reset_priority", 1'b0, 16'h0000, 1'b0);
        reset_n = 1'b1;
        drive(1'b0, 16'h89FF, 16'h01FF);
        expect_out("post_reset", 1'b0, 16'h0000, 1'b0);

        hold_a  = 16'h0000;
        hold_st = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            l = 16'($urandom);
            s = 16'($urandom);
            if (i % 2 == 0 && s[14:10] > l[14:10])
                s[14:10] = 5'($urandom_range(0, int'(l[14:10])));
            m = ref_align(l, s);
            if (v) begin
                hold_a  = m[15:0];
                hold_st = m[16];
            end
            drive(v, l, s);
            expect_out("random", v, hold_a, hold_st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
